// File: rtl/xxhash32_arbiter.sv
// xxhash32_arbiter: round-robin sequencer sharing one xxhash32 core among
// NUM_REQ streaming requesters. Each message is a seed beat followed by zero
// or more data words; the finished hash goes back over a valid/ready channel.
// Optional stall timeout: define XXHASH_ARB_TIMEOUT_EN to enable it.
module xxhash32_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     s_valid,
    input  logic [NUM_REQ*32-1:0]  s_data,
    input  logic [NUM_REQ-1:0]     s_last,
    output logic [NUM_REQ-1:0]     s_ready,
    output logic [NUM_REQ-1:0]     res_valid,
    input  logic [NUM_REQ-1:0]     res_ready,
    output logic [31:0]            res_hash,
    output logic                   res_err,
    output logic                   core_seed_in,
    output logic                   core_add_to_hash,
    output logic                   core_request_hash,
    output logic [31:0]            core_input_bytes,
    input  logic [31:0]            core_output_hash
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_DATA, S_DRAIN, S_FINAL, S_CAPTURE, S_RESULT
    } state_t;

    state_t          r_state, w_next;
    logic [GW-1:0]   r_gnt, r_last_grant, w_pick;
    logic            w_any;
    logic [31:0]     w_words [NUM_REQ];
    logic [31:0]     w_sd;
    logic            w_sv, w_sl, w_rr;
    logic [31:0]     r_res_hash;
    int              w_idx;

`ifdef XXHASH_ARB_TIMEOUT_EN
    logic [15:0]     r_tmo;
    logic            r_res_err;
    logic            w_tmo_hit, w_tmo;
`endif

    // Unpack the flat data bus into one word per requester
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign w_words[g] = s_data[g*32 +: 32];
    end

    assign w_sd = w_words[r_gnt];
    assign w_sv = s_valid[r_gnt];
    assign w_sl = s_last[r_gnt];
    assign w_rr = res_ready[r_gnt];

    // Round-robin pick: first valid requester strictly after the last grant
    always_comb begin
        w_pick = r_last_grant;
        w_any  = 1'b0;
        w_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(r_last_grant) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_any && s_valid[GW'(w_idx)]) begin
                w_any  = 1'b1;
                w_pick = GW'(w_idx);
            end
        end
    end

`ifdef XXHASH_ARB_TIMEOUT_EN
    // The cycle that completes TIMEOUT_CYCLES consecutive stalls aborts
    assign w_tmo_hit = (r_tmo == 16'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state and strobe decode; strobes only ever come from one state
    always_comb begin
        w_next            = r_state;
        s_ready           = '0;
        res_valid         = '0;
        core_seed_in      = 1'b0;
        core_add_to_hash  = 1'b0;
        core_request_hash = 1'b0;
        core_input_bytes  = 32'd0;
`ifdef XXHASH_ARB_TIMEOUT_EN
        w_tmo             = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any) w_next = S_SEED;
            end
            S_SEED: begin
                s_ready[r_gnt] = 1'b1;
                if (w_sv) begin
                    core_seed_in     = 1'b1;
                    core_input_bytes = w_sd;
                    w_next           = w_sl ? S_DRAIN : S_DATA;
                end
`ifdef XXHASH_ARB_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_tmo  = 1'b1;
                    w_next = S_RESULT;
                end
`endif
            end
            S_DATA: begin
                s_ready[r_gnt] = 1'b1;
                if (w_sv) begin
                    core_add_to_hash = 1'b1;
                    core_input_bytes = w_sd;
                    if (w_sl) w_next = S_DRAIN;
                end
`ifdef XXHASH_ARB_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_tmo  = 1'b1;
                    w_next = S_RESULT;
                end
`endif
            end
            // Core needs one quiet cycle to fold a just-completed stripe
            S_DRAIN:   w_next = S_FINAL;
            S_FINAL: begin
                core_request_hash = 1'b1;
                w_next            = S_CAPTURE;
            end
            S_CAPTURE: w_next = S_RESULT;
            S_RESULT: begin
                res_valid[r_gnt] = 1'b1;
                if (w_rr) w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // State, grant and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gnt        <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_any) r_gnt <= w_pick;
            if (r_state == S_RESULT && w_rr) r_last_grant <= r_gnt;
        end
    end

    // Result register: held stable for the whole RESULT phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_hash <= 32'd0;
`ifdef XXHASH_ARB_TIMEOUT_EN
            r_res_err  <= 1'b0;
`endif
        end else if (r_state == S_CAPTURE) begin
            r_res_hash <= core_output_hash;
`ifdef XXHASH_ARB_TIMEOUT_EN
            r_res_err  <= 1'b0;
        end else if (w_tmo) begin
            r_res_hash <= 32'd0;
            r_res_err  <= 1'b1;
`endif
        end
    end

`ifdef XXHASH_ARB_TIMEOUT_EN
    // Consecutive stalled SEED/DATA cycles; any handshake restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= 16'd0;
        end else if ((r_state == S_SEED || r_state == S_DATA) && !w_sv) begin
            r_tmo <= r_tmo + 16'd1;
        end else begin
            r_tmo <= 16'd0;
        end
    end
    assign res_err = r_res_err;
`else
    assign res_err = 1'b0;
`endif

    assign res_hash = r_res_hash;

endmodule

// File: tb/tb_xxhash32_arbiter.sv
// Bench for xxhash32_arbiter: behavioural xxhash32 core plus a
// specification-level XXH32 reference and per-requester message queues.
module tb_xxhash32_arbiter;

    localparam int NR = 4;
`ifdef XXHASH_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    localparam logic [31:0] P1 = 32'h9E3779B1, P2 = 32'h85EBCA77,
                            P3 = 32'hC2B2AE3D, P4 = 32'h27D4EB2F,
                            P5 = 32'h165667B1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     s_valid, s_last, s_ready, res_valid, res_ready;
    logic [NR*32-1:0]  s_data;
    logic [31:0]       res_hash, core_input_bytes, core_output_hash;
    logic              res_err, core_seed_in, core_add_to_hash, core_request_hash;

    always #5 clk = ~clk;

    xxhash32_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hash(res_hash), .res_err(res_err),
        .core_seed_in(core_seed_in), .core_add_to_hash(core_add_to_hash),
        .core_request_hash(core_request_hash),
        .core_input_bytes(core_input_bytes), .core_output_hash(core_output_hash)
    );

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
        return (x << r) | (x >> (32 - r));
    endfunction

    // XXH32 of n little-endian 32-bit words
    function automatic logic [31:0] xxh32(input logic [31:0] seed, input logic [31:0] w[64], input int n);
        logic [31:0] v[4];
        logic [31:0] h;
        int i;
        i = 0;
        if (n >= 4) begin
            v[0] = seed + P1 + P2; v[1] = seed + P2; v[2] = seed; v[3] = seed - P1;
            while (i + 4 <= n) begin
                for (int j = 0; j < 4; j++) v[j] = rotl(v[j] + w[i+j] * P2, 13) * P1;
                i += 4;
            end
            h = rotl(v[0], 1) + rotl(v[1], 7) + rotl(v[2], 12) + rotl(v[3], 18);
        end else begin
            h = seed + P5;
        end
        h += 32'(4 * n);
        while (i < n) begin
            h = rotl(h + w[i] * P3, 17) * P4;
            i++;
        end
        h ^= h >> 15; h *= P2; h ^= h >> 13; h *= P3; h ^= h >> 16;
        return h;
    endfunction

    // Requester beat queues and expected-result queues
    logic [31:0] bd [NR][256];
    logic        bl [NR][256];
    logic        bs [NR][256];
    int          bh [NR], bt [NR];
    logic [31:0] eh [NR][64];
    logic        ee [NR][64];
    int          eh_h [NR], eh_t [NR];
    logic        gap [NR];
    int          hold [NR];
    int          glog [64];
    int          gn = 0;
    logic [31:0] mw [64];

    // Behavioural core state
    logic [31:0] cseed;
    logic [31:0] cw [64];
    int          cn = 0, lastst = 0;
    logic        cpend = 1'b0;

    int   cyc = 0, last_hs = 0, last_beat = 0, last_res = -1, seed_cyc = 0;
    int   nseed = 0, nadd = 0, nreq = 0, nres = 0, rvc = 0, lastrvc = 0;
    logic rv_seen = 1'b0, b2b = 1'b0;

    task automatic push(input int r, input logic [31:0] d, input logic last, input logic sd);
        bd[r][bt[r] % 256] = d;
        bl[r][bt[r] % 256] = last;
        bs[r][bt[r] % 256] = sd;
        bt[r]++;
    endtask

    // Queue a message built from mw[0..n-1]; abort = never marked last
    task automatic send(input int r, input logic [31:0] seed, input int n, input logic abort);
        push(r, seed, (n == 0) && !abort, 1'b1);
        for (int k = 0; k < n; k++) push(r, mw[k], (k == n - 1) && !abort, 1'b0);
        eh[r][eh_t[r] % 64] = abort ? 32'd0 : xxh32(seed, mw, n);
        ee[r][eh_t[r] % 64] = abort;
        eh_t[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (bh[i] != bt[i]) begin
                s_valid[i] = !(gap[i] && $urandom_range(0, 2) == 0);
                s_data[i*32 +: 32] = bd[i][bh[i] % 256];
                s_last[i] = bl[i][bh[i] % 256];
            end else begin
                s_valid[i] = 1'b0;
                s_data[i*32 +: 32] = 32'd0;
                s_last[i] = 1'b0;
            end
            res_ready[i] = (hold[i] == 0);
        end
    endtask

    // One clock: observe at negedge, update core model and stimulus after posedge
    task automatic step();
        logic [NR-1:0] pop;
        int ns, k, e;
        pop = '0;
        @(negedge clk);
        cyc++;
        chk("s_ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
        chk("res_valid_onehot", 32'($countones(res_valid) <= 1), 32'd1);
        ns = int'(core_seed_in) + int'(core_add_to_hash) + int'(core_request_hash);
        chk("strobe_overlap", 32'(ns <= 1), 32'd1);
        if (ns == 0) chk("bytes_idle", core_input_bytes, 32'd0);
`ifndef XXHASH_ARB_TIMEOUT_EN
        chk("res_err_tied", 32'(res_err), 32'd0);
`endif
        for (int i = 0; i < NR; i++) begin
            if (s_valid[i] && s_ready[i]) begin
                k = bh[i] % 256;
                chk("seed_strobe", 32'(core_seed_in), 32'(bs[i][k]));
                chk("add_strobe", 32'(core_add_to_hash), 32'(!bs[i][k]));
                chk("core_bytes", core_input_bytes, bd[i][k]);
                if (bs[i][k]) begin
                    glog[gn % 64] = i; gn++;
                    seed_cyc = cyc;
                    if (b2b && last_res >= 0) chk("idle_gap", cyc - last_res, 32'd2);
                end
                last_hs = cyc;
                if (bl[i][k]) last_beat = cyc;
                pop[i] = 1'b1;
            end
        end
        if (core_seed_in) begin cseed = core_input_bytes; cn = 0; lastst = cyc; nseed++; end
        if (core_add_to_hash) begin cw[cn % 64] = core_input_bytes; cn++; lastst = cyc; nadd++; end
        if (core_request_hash) begin nreq++; chk("drain_gap", cyc - lastst, 32'd2); cpend = 1'b1; end
        for (int i = 0; i < NR; i++) begin
            if (res_valid[i]) begin
                if (eh_h[i] == eh_t[i]) begin
                    chk("res_spurious", 32'(eh_t[i] - eh_h[i]), 32'd1);
                end else begin
                    e = eh_h[i] % 64;
                    if (!rv_seen) begin
                        rv_seen = 1'b1;
                        if (ee[i][e]) chk("tmo_latency", cyc - last_hs, TMO + 1);
                        else          chk("res_latency", cyc - last_beat, 32'd4);
                    end
                    chk("res_hash", res_hash, eh[i][e]);
                    chk("res_err", 32'(res_err), 32'(ee[i][e]));
                    rvc++;
                    if (res_ready[i]) begin
                        eh_h[i]++; rv_seen = 1'b0; last_res = cyc; nres++;
                        lastrvc = rvc; rvc = 0;
                    end else if (hold[i] > 0) begin
                        hold[i]--;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (pop[i]) bh[i]++;
        if (cpend) begin core_output_hash = xxh32(cseed, cw, cn); cpend = 1'b0; end
        drive();
    endtask

    task automatic wait_res(input int n, input int budget, input string tag);
        int s, c;
        s = nres; c = 0;
        while (nres - s < n && c < budget) begin step(); c++; end
        chk(tag, 32'(nres - s), 32'(n));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_hash"}, res_hash, 32'd0);
        chk({tag, "_res_err"}, 32'(res_err), 32'd0);
        chk({tag, "_strobes"}, 32'({core_seed_in, core_add_to_hash, core_request_hash}), 32'd0);
        chk({tag, "_bytes"}, core_input_bytes, 32'd0);
    endtask

    initial begin
        int a, b, c, cnt, gn0, r;
        int exp_ord[5];
        exp_ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NR; i++) begin
            bh[i] = 0; bt[i] = 0; eh_h[i] = 0; eh_t[i] = 0; gap[i] = 1'b0; hold[i] = 0;
        end
        for (int i = 0; i < 64; i++) mw[i] = 32'd0;
        rst_n = 1'b0; s_valid = '0; s_data = '0; s_last = '0; res_ready = '1;
        core_output_hash = 32'd0;

        chk("xxh_empty_ref", xxh32(32'd0, mw, 0), 32'h02CC5D05);

        // Reset state, with requests pending
        s_valid = '1;
        #12;
        chk_all_zero("reset");
        s_valid = '0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Requester 0: zero-word message, seed 0
        send(0, 32'd0, 0, 1'b0);
        drive();
        wait_res(1, 50, "t1_done");

        // Requester 2: seed 0x12345678, words 1..7 back to back
        a = nseed; b = nadd; c = nreq;
        for (int k = 0; k < 7; k++) mw[k] = 32'(k + 1);
        send(2, 32'h12345678, 7, 1'b0);
        drive();
        wait_res(1, 100, "t2_done");
        chk("t2_seeds", 32'(nseed - a), 32'd1);
        chk("t2_adds", 32'(nadd - b), 32'd7);
        chk("t2_reqs", 32'(nreq - c), 32'd1);
        chk("t2_throughput", 32'(last_beat - seed_cyc), 32'd7);

        // Requester 1: gappy 8-word message, result held off for 10 cycles
        for (int k = 0; k < 8; k++) mw[k] = $urandom;
        gap[1] = 1'b1; hold[1] = 10;
        send(1, $urandom, 8, 1'b0);
        drive();
        wait_res(1, 200, "t4_done");
        chk("t4_held_cycles", 32'(lastrvc), 32'd11);
        gap[1] = 1'b0;

        // Reset in the middle of a DATA phase
        for (int k = 0; k < 12; k++) mw[k] = $urandom;
        send(2, $urandom, 12, 1'b0);
        drive();
        a = nadd; cnt = 0;
        while (nadd - a < 3 && cnt < 50) begin step(); cnt++; end
        chk("t5_in_data", 32'(nadd - a >= 3), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        for (int i = 0; i < NR; i++) begin bh[i] = bt[i]; eh_h[i] = eh_t[i]; hold[i] = 0; end
        cpend = 1'b0; cn = 0; rv_seen = 1'b0; rvc = 0; last_res = -1;

        // All four requesters pending at reset release, one word each
        for (int q = 0; q < 5; q++) begin
            mw[0] = $urandom;
            send(exp_ord[q], $urandom, 1, 1'b0);
        end
        b2b = 1'b1; gn0 = gn;
        drive();
        repeat (2) step();
        rst_n = 1'b1;
        wait_res(5, 300, "t3_done");
        for (int q = 0; q < 5; q++) chk("t3_order", 32'(glog[(gn0 + q) % 64]), 32'(exp_ord[q]));
        b2b = 1'b0;

        // Random traffic
        for (int m = 0; m < 12; m++) begin
            r = $urandom_range(0, NR - 1);
            cnt = $urandom_range(0, 9);
            for (int k = 0; k < cnt; k++) mw[k] = $urandom;
            gap[r] = 1'($urandom_range(0, 1));
            hold[r] = $urandom_range(0, 3);
            send(r, $urandom, cnt, 1'b0);
        end
        drive();
        wait_res(12, 3000, "rand_done");
        for (int i = 0; i < NR; i++) gap[i] = 1'b0;

`ifdef XXHASH_ARB_TIMEOUT_EN
        // Requester 0 stalls for good after two words
        a = nreq;
        mw[0] = $urandom; mw[1] = $urandom;
        send(0, $urandom, 2, 1'b1);
        drive();
        wait_res(1, 100, "tmo_done");
        chk("tmo_no_request", 32'(nreq - a), 32'd0);
        for (int k = 0; k < 5; k++) mw[k] = $urandom;
        send(0, $urandom, 5, 1'b0);
        drive();
        wait_res(1, 100, "tmo_next");
`endif

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
